dlfloat_mul_seq_ctrl: RTL and testbench

//  Sequenced DLFloat (7-bit exp, 9-bit explicit fraction, unsigned) multiplier unit.
//  FSM-driven shift-add fraction multiply, then iterative post-normalisation.

---
 rtl/dlfloat_mul_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_dlfloat_mul_seq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_mul_seq_ctrl.sv
// Sequenced DLFloat multiplier: shift-add fraction multiply, iterative normalise.
// Ports: clk, rst (sync, high), in_valid/in_ready + flp_a/flp_b operands,
//   out_valid/out_ready + result/ovf/unf, busy (MUL, NORM, DONE).
module dlfloat_mul_seq_ctrl #(
  parameter int EXP_W  = 7,
  parameter int FRAC_W = 9,
  parameter int BIAS   = 63
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W-1:0]   flp_a,
  input  logic [EXP_W+FRAC_W-1:0]   flp_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W-1:0]   result,
  output logic                      ovf,
  output logic                      unf,
  output logic                      busy
);

  localparam int F  = FRAC_W;
  localparam int W  = EXP_W + FRAC_W;
  localparam int EW = EXP_W + 3;
  localparam int CW = $clog2(FRAC_W);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  state_t state, state_n;

  // Low half of acc starts out holding the multiplier; its LSB is the
  // add decision and product bits fill in from the top as it drains.
  logic [2*F-1:0] acc;
  logic [F-1:0]   frac_a;
  logic [CW-1:0]  cnt;
  logic [F-1:0]   prod;
  logic [EW-1:0]  exp_r;
  logic           zero;

  logic [F:0]     sum;
  logic [2*F-1:0] acc_nxt;
  logic           last;
  logic           ovf_c;
  logic           unf_c;

  assign sum = {1'b0, acc[2*F-1:F]}
             + (acc[0] ? {1'b0, frac_a} : '0);
  assign acc_nxt = {sum, acc[F-1:1]};
  assign last = (cnt == CW'(F - 1));

  // exp_r is two's complement; above EXP_W bits any set bit with a
  // clear sign means the exponent no longer fits.
  assign unf_c = exp_r[EW-1];
  assign ovf_c = !exp_r[EW-1] && (exp_r[EW-2:EXP_W] != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      frac_a <= '0;
      cnt    <= '0;
      prod   <= '0;
      exp_r  <= '0;
      zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            frac_a <= flp_a[F-1:0];
            acc    <= {{F{1'b0}}, flp_b[F-1:0]};
            cnt    <= '0;
            zero   <= 1'b0;
            exp_r  <= EW'(flp_a[W-1:F])
                    + EW'(flp_b[W-1:F])
                    - EW'(BIAS);
          end
        end
        MUL: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last) prod <= acc_nxt[2*F-1:F];
        end
        NORM: begin
          if (prod == '0) begin
            zero <= 1'b1;
          end else if (!prod[F-1]) begin
            prod  <= {prod[F-2:0], 1'b0};
            exp_r <= exp_r - EW'(1);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    result    = '0;
    ovf       = 1'b0;
    unf       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_n = MUL;
      end
      MUL: begin
        if (last) state_n = NORM;
      end
      NORM: begin
        if (prod == '0 || prod[F-1]) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (zero) begin
          result = '0;
        end else if (ovf_c) begin
          result = '1;
          ovf    = 1'b1;
        end else if (unf_c) begin
          unf    = 1'b1;
        end else begin
          result = {exp_r[EXP_W-1:0], prod};
        end
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dlfloat_mul_seq_ctrl.sv
// Bench for dlfloat_mul_seq_ctrl: vector table plus handshake,
// backpressure, ignored-input and mid-operation reset sequences.
module tb_dlfloat_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] flp_a = '0;
  logic [15:0] flp_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic        ovf;
  logic        unf;
  logic        busy;

  int total = 0;
  int bad = 0;

  dlfloat_mul_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .flp_a(flp_a), .flp_b(flp_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .unf(unf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ov;
    logic        un;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a,
                        input logic [15:0] b,
                        input bit pulse,
                        output int lat,
                        output bit rdy_ok);
    @(negedge clk);
    flp_a = a;
    flp_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    rdy_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready || !busy) rdy_ok = 1'b0;
      if (pulse && lat == 2) begin
        flp_a = 16'h7FFF;
        flp_b = 16'h7FFF;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    if (in_ready || !busy) rdy_ok = 1'b0;
  endtask

  task automatic release_out(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, " in_ready after"}, in_ready, 1);
    chk({name, " out_valid after"}, out_valid, 0);
    chk({name, " busy after"}, busy, 0);
  endtask

  initial begin
    int lat;
    bit rok;
    string nm;

    vecs[0]  = '{16'h7F00, 16'h7F00, 16'h7D00, 0, 0, 11};
    vecs[1]  = '{16'h7FFF, 16'h7FFF, 16'h7FFE, 0, 0, 10};
    vecs[2]  = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 0, 10};
    vecs[3]  = '{16'h0100, 16'h0100, 16'h0000, 0, 1, 11};
    vecs[4]  = '{16'h7E00, 16'h7FFF, 16'h0000, 0, 0, 10};
    vecs[5]  = '{16'h8100, 16'h7FFF, 16'h7FFE, 0, 0, 11};
    vecs[6]  = '{16'h7E01, 16'h7FFF, 16'h0000, 0, 0, 10};
    vecs[7]  = '{16'hFFFF, 16'h7FFF, 16'hFFFE, 0, 0, 10};
    vecs[8]  = '{16'h7FFF, 16'h01FF, 16'h01FE, 0, 0, 10};
    vecs[9]  = '{16'hFFFF, 16'h81FF, 16'hFFFF, 1, 0, 10};
    vecs[10] = '{16'hFFFF, 16'h8100, 16'hFFFE, 0, 0, 11};
    vecs[11] = '{16'h01FF, 16'h7F00, 16'h0000, 0, 1, 11};

    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst result", result, 0);
    chk("rst ovf", ovf, 0);
    chk("rst unf", unf, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      nm = $sformatf("v%0d", i);
      run_op(vecs[i].a, vecs[i].b, 1'b0, lat, rok);
      chk({nm, " result"}, result, vecs[i].res);
      chk({nm, " ovf"}, ovf, vecs[i].ov);
      chk({nm, " unf"}, unf, vecs[i].un);
      chk({nm, " latency"}, lat, vecs[i].lat);
      chk({nm, " in_ready low"}, rok, 1);
      release_out(nm);
    end

    // Second in_valid pulse mid-operation must not be latched.
    run_op(16'h7E00, 16'h7FFF, 1'b1, lat, rok);
    chk("pulse result", result, 16'h0000);
    chk("pulse latency", lat, 10);
    chk("pulse in_ready low", rok, 1);
    release_out("pulse");
    repeat (3) @(posedge clk);
    #1;
    chk("pulse no extra op", busy, 0);

    // Backpressure: result and flags hold while out_ready is low.
    run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, rok);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      nm = $sformatf("bp%0d", i);
      chk({nm, " out_valid"}, out_valid, 1);
      chk({nm, " result"}, result, 16'hFFFF);
      chk({nm, " ovf"}, ovf, 1);
      chk({nm, " in_ready"}, in_ready, 0);
    end
    release_out("bp");
    chk("bp ovf cleared", ovf, 0);

    // Reset during MUL cycle 4 drops the operation.
    @(negedge clk);
    flp_a = 16'h7F00;
    flp_b = 16'h7F00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid rst out_valid", out_valid, 0);
    chk("mid rst result", result, 0);
    chk("mid rst in_ready", in_ready, 1);
    chk("mid rst busy", busy, 0);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid rst no result", out_valid, 0);

    run_op(16'h7F00, 16'h7F00, 1'b0, lat, rok);
    chk("after rst result", result, 16'h7D00);
    chk("after rst latency", lat, 11);
    chk("after rst flags", {ovf, unf}, 0);
    release_out("after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
